// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register fed by the decode-stage register file.
// Captures decoded fields plus bypassed operands, inserts bubbles on flush or
// load-use hazard, and raises stall_out back to fetch/decode.
// Optional build macro: ID_EX_PERF_EN adds saturating stall/flush counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_rdata1,
  input  logic [DATA_W-1:0] in_rdata2,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_mem_read,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_we,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic              stall_out
`ifdef ID_EX_PERF_EN
  ,
  output logic [DATA_W-1:0] perf_stall_cnt,
  output logic [DATA_W-1:0] perf_flush_cnt
`endif
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [CTRL_W-1:0] CTRL_ZERO = {CTRL_W{1'b0}};

  // Register-file writes land on the clock edge, so a same-cycle write to the
  // source index must be forwarded; index 0 is hard-wired to zero.
  function automatic logic [DATA_W-1:0] bypass_operand(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] rdata,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] result;
    if (idx == ADDR_ZERO) begin
      result = DATA_ZERO;
    end else if (we && (waddr == idx)) begin
      result = wdata;
    end else begin
      result = rdata;
    end
    return result;
  endfunction

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] pc_q,        pc_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [DATA_W-1:0] op_a_q,      op_a_d;
  logic [DATA_W-1:0] op_b_q,      op_b_d;
  logic [ADDR_W-1:0] rs_q,        rs_d;
  logic [ADDR_W-1:0] rt_q,        rt_d;
  logic [ADDR_W-1:0] dest_q,      dest_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic              mem_read_q,  mem_read_d;
  logic              reg_write_q, reg_write_d;
  logic              stall_s;

  // Load-use hazard: the load in EX produces a register decode wants to read.
  always_comb begin
    stall_s = valid_q & mem_read_q & (dest_q != ADDR_ZERO) & in_valid &
              ((dest_q == in_rs) | (dest_q == in_rt));
  end

  assign stall_out = stall_s;

  // Next EX entry: hold on halt, bubble on flush/stall, otherwise capture.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    ctrl_d      = ctrl_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    if (halt) begin
      valid_d = valid_q;
    end else if (flush || stall_s) begin
      valid_d     = 1'b0;
      pc_d        = DATA_ZERO;
      imm_d       = DATA_ZERO;
      op_a_d      = DATA_ZERO;
      op_b_d      = DATA_ZERO;
      rs_d        = ADDR_ZERO;
      rt_d        = ADDR_ZERO;
      dest_d      = ADDR_ZERO;
      ctrl_d      = CTRL_ZERO;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
    end else begin
      valid_d     = in_valid;
      pc_d        = in_pc;
      imm_d       = in_imm;
      op_a_d      = bypass_operand(in_rs, in_rdata1, wb_we, wb_addr, wb_data);
      op_b_d      = bypass_operand(in_rt, in_rdata2, wb_we, wb_addr, wb_data);
      rs_d        = in_rs;
      rt_d        = in_rt;
      dest_d      = in_dest;
      ctrl_d      = in_valid ? in_ctrl : CTRL_ZERO;
      mem_read_d  = in_valid & in_mem_read;
      reg_write_d = in_valid & in_reg_write;
    end
  end

  // EX entry flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= DATA_ZERO;
      imm_q       <= DATA_ZERO;
      op_a_q      <= DATA_ZERO;
      op_b_q      <= DATA_ZERO;
      rs_q        <= ADDR_ZERO;
      rt_q        <= ADDR_ZERO;
      dest_q      <= ADDR_ZERO;
      ctrl_q      <= CTRL_ZERO;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_op_a      = op_a_q;
  assign ex_op_b      = op_b_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_dest      = dest_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;

`ifdef ID_EX_PERF_EN
  localparam logic [DATA_W-1:0] DATA_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; flush takes priority so a flushed stall is not a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!halt && flush && (flush_cnt_q != DATA_ONES)) begin
      flush_cnt_d = flush_cnt_q + DATA_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
    if (!halt && !flush && stall_s && (stall_cnt_q != DATA_ONES)) begin
      stall_cnt_d = stall_cnt_q + DATA_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= DATA_ZERO;
      flush_cnt_q <= DATA_ZERO;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly downstream of the decode-stage register file.
- Captures decoded fields and register-file read data each cycle and presents them to the execute stage.
- Inserts bubbles on flush or load-use hazard and drives the stall request back to fetch/decode.
- Applies a same-cycle writeback bypass, because register-file writes only land on the clock edge.

Parameters:
- DATA_W, 32, width of data/PC/immediate words (equals PC_BITS).
- ADDR_W, 5, register index width (equals PC_ADDR_SIZE).
- CTRL_W, 8, width of opaque execute/memory control bundle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- halt  in  1  global freeze; hold all state
- flush  in  1  branch/jump squash; next captured entry is a bubble
- in_valid  in  1  decode entry valid
- in_pc  in  DATA_W  PC of decoded instruction
- in_rs, in_rt  in  ADDR_W each  source register indices (the register-file read addresses)
- in_dest  in  ADDR_W  destination register index, already selected by decode
- in_imm  in  DATA_W  sign/zero-extended immediate
- in_rdata1, in_rdata2  in  DATA_W each  register-file read data
- in_ctrl  in  CTRL_W  control bundle
- in_mem_read  in  1  instruction is a load
- in_reg_write  in  1  instruction writes a register
- wb_addr  in  ADDR_W  writeback address, the same signal that feeds the register file
- wb_data  in  DATA_W  writeback data
- wb_we  in  1  writeback enable
- ex_valid  out  1  EX entry valid
- ex_pc, ex_imm, ex_op_a, ex_op_b  out  DATA_W each  registered fields and operands
- ex_rs, ex_rt, ex_dest  out  ADDR_W each  registered indices
- ex_ctrl  out  CTRL_W  registered control
- ex_mem_read, ex_reg_write  out  1 each  registered control bits
- stall_out  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset: all registered outputs are 0 on the first posedge with rst=1. stall_out=0 after reset because ex_valid=0.
- Load-use hazard (combinational): stall_out = ex_valid & ex_mem_read & (ex_dest!=0) & in_valid & (ex_dest==in_rs | ex_dest==in_rt). It is independent of halt and flush.
- Bypass, per operand:
  - Index 0 yields 0.
  - Otherwise, if wb_we and wb_addr equals the index, the operand is wb_data.
  - Otherwise the operand is the corresponding in_rdataN.
- Posedge update priority:
  1. rst: clear all.
  2. halt: hold all registers unchanged.
  3. flush: capture bubble.
  4. stall_out: capture bubble.
  5. Otherwise capture the inputs.
- Bubble: ex_valid, ex_mem_read, ex_reg_write, ex_ctrl, ex_dest = 0; all other fields = 0.
- Capture:
  - ex_valid=in_valid.
  - Fields are copied.
  - ex_op_a/ex_op_b come from the bypassed operands.
  - If in_valid=0, ex_mem_read, ex_reg_write, ex_ctrl are forced to 0.
- Latency: one cycle from inputs to EX outputs. A load-use hazard inserts exactly one bubble; on the following cycle the load has left EX, so the dependent instruction is captured.
- Simultaneous events:
  - flush with a stall: flush wins, and stall_out still asserts (harmless).
  - halt with flush: halt wins and the flush is lost, so the upstream must hold flush until halt deasserts.
  - rst mid-hazard: entry is cleared and stall_out drops the next cycle.

Optional Feature:
- Macro: ID_EX_PERF_EN.
- When defined:
  - Adds outputs perf_stall_cnt and perf_flush_cnt, each DATA_W wide.
  - These are saturating counters, reset to 0.
  - Each increments on every non-halted posedge where the stall (respectively flush) bubble path is taken.
  - Saturation holds at all-ones.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, stall_out=0.
- Plain capture: in_valid=1, in_rs=3, in_rt=4, in_rdata1=0x11, in_rdata2=0x22, wb_we=0 -> next cycle ex_op_a=0x11, ex_op_b=0x22, ex_valid=1.
- Bypass:
  - wb_we=1, wb_addr=4, wb_data=0xDEAD, in_rt=4, in_rdata2=0x22 -> ex_op_b=0xDEAD.
  - wb_addr=0 with in_rs=0 -> ex_op_a=0.
- Load-use: EX holds a load with ex_dest=5; decode has in_rs=5 -> stall_out=1 the same cycle, next cycle ex_valid=0; following cycle the dependent instruction is captured and stall_out=0.
- Flush/halt priority:
  - flush=1 with a valid input -> bubble.
  - halt=1 with flush=1 -> EX outputs unchanged for as many cycles as halt is held.
- Perf (ID_EX_PERF_EN): 3 load-use stalls and 2 flushes -> perf_stall_cnt=3, perf_flush_cnt=2; a preloaded all-ones counter stays all-ones.
